// File: rtl/fpu_mul_pkg.sv
// Shared types and constants for the FPU multiply path.
package fpu_mul_pkg;

  // Controller states. Encoding 2'd3 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Single-precision mantissa width including the hidden bit.
  localparam int MANT_W = 24;

endpackage

// File: rtl/rca_adder.sv
// Ripple-carry adder built from a chain of full-adder cells.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // One-bit full adder.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

module rca_adder #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    fa_cell u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (Sum[i]),
      .co (carry[i+1])
    );
  end

  assign Cout = carry[WIDTH];

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential radix-2 shift-and-add mantissa multiplier. One shared adder is
// stepped over WIDTH iterations to build a 2*WIDTH-bit product.
//
// Handshakes:
//   upstream   - a multiply is accepted on a rising edge where start=1 and
//                in_ready=1 (IDLE only); start in any other state is dropped.
//   downstream - product is presented with out_valid=1 and held stable until a
//                rising edge with out_valid=1 and out_ready=1 completes the
//                transfer.
//   flush aborts any state back to IDLE; it overrides start and out_ready.
module mant_mul_seq
  import fpu_mul_pkg::*;
#(
  parameter  int WIDTH = MANT_W,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  mul_state_t       state_q,  state_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Add the multiplicand only when the current multiplier LSB is set.
  always_comb begin
    addend = acc_lo_q[0] ? mcand_q : '0;
  end

  rca_adder #(.WIDTH(WIDTH)) u_adder (
    .A    (acc_hi_q),
    .B    (addend),
    .Cin  (1'b0),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // State, counter and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
    end
  end

  // Next-state and datapath update. The carry-out becomes the new top bit of
  // acc_hi as the whole {carry, sum, acc_lo} word shifts right by one.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = RUN;
            mcand_d  = mcand;
            acc_lo_d = mplier;
            acc_hi_d = '0;
            count_d  = '0;
          end
        end
        RUN: begin
          acc_hi_d = {add_cout, add_sum[WIDTH-1:1]};
          acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
          count_d  = count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
    product   = {acc_hi_q, acc_lo_q};
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_mant_mul_seq.sv
// Bench for mant_mul_seq: directed vector table plus corner sequences on a
// 24-bit instance, then a scoreboarded random sweep on 24- and 8-bit instances.
module tb_mant_mul_seq;
  import fpu_mul_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 24-bit instance ----------------
  logic        start24, flush24, out_ready24;
  logic [23:0] mcand24, mplier24;
  logic        in_ready24, out_valid24, busy24;
  logic [47:0] product24;
  logic [1:0]  dbg24;

  mant_mul_seq #(.WIDTH(24)) u_dut24 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start24),
    .in_ready  (in_ready24),
    .mcand     (mcand24),
    .mplier    (mplier24),
    .flush     (flush24),
    .out_valid (out_valid24),
    .out_ready (out_ready24),
    .product   (product24),
    .busy      (busy24),
    .state_dbg (dbg24)
  );

  // ---------------- 8-bit instance ----------------
  logic        start8, flush8, out_ready8;
  logic [7:0]  mcand8, mplier8;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] product8;
  logic [1:0]  dbg8;

  mant_mul_seq #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start8),
    .in_ready  (in_ready8),
    .mcand     (mcand8),
    .mplier    (mplier8),
    .flush     (flush8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .product   (product8),
    .busy      (busy8),
    .state_dbg (dbg8)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid; lat counts edges since the accept edge (already 1).
  task automatic wait_valid24(inout int lat, inout int bcnt);
    while (!out_valid24 && lat < 100) begin
      step();
      lat++;
      if (busy24) bcnt++;
    end
  endtask

  // Present operands for one edge, then scramble inputs while it runs.
  task automatic run24(input logic [23:0] a, input logic [23:0] b,
                       output int lat, output int bcnt);
    mcand24  = a;
    mplier24 = b;
    start24  = 1'b1;
    step();
    start24  = 1'b0;
    mcand24  = 24'($urandom);
    mplier24 = 24'($urandom);
    lat  = 1;
    bcnt = busy24 ? 1 : 0;
    wait_valid24(lat, bcnt);
  endtask

  task automatic rand24(input int n);
    logic [47:0] exp_q[$];
    logic [47:0] exp;
    logic [23:0] a, b;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while ((sent < n || exp_q.size() > 0) && cyc < 40000) begin
      out_ready24 = ($urandom_range(0, 3) != 0);
      if (out_valid24 && out_ready24) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("r24_product", 64'(product24), 64'(exp));
        got++;
      end
      if (in_ready24 && sent < n && $urandom_range(0, 1) == 1) begin
        a = 24'($urandom);
        b = 24'($urandom);
        mcand24  = a;
        mplier24 = b;
        start24  = 1'b1;
        exp_q.push_back(48'(a) * 48'(b));
        sent++;
      end else begin
        start24 = 1'b0;
      end
      step();
      cyc++;
    end
    start24     = 1'b0;
    out_ready24 = 1'b1;
    chk("r24_left", 64'(exp_q.size()), 64'd0);
    chk("r24_count", 64'(got), 64'(n));
  endtask

  task automatic rand8(input int n);
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    logic [7:0]  a, b;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while ((sent < n || exp_q.size() > 0) && cyc < 40000) begin
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (out_valid8 && out_ready8) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("r8_product", 64'(product8), 64'(exp));
        got++;
      end
      if (in_ready8 && sent < n && $urandom_range(0, 1) == 1) begin
        a = 8'($urandom);
        b = 8'($urandom);
        mcand8  = a;
        mplier8 = b;
        start8  = 1'b1;
        exp_q.push_back(16'(a) * 16'(b));
        sent++;
      end else begin
        start8 = 1'b0;
      end
      step();
      cyc++;
    end
    start8     = 1'b0;
    out_ready8 = 1'b1;
    chk("r8_left", 64'(exp_q.size()), 64'd0);
    chk("r8_count", 64'(got), 64'(n));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
  } vec_t;

  vec_t vecs[8];

  // Global time guard.
  initial begin
    #1500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, bcnt;
    logic seen;

    vecs[0] = '{"all_ones",   24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    vecs[1] = '{"hidden_bit", 24'h800000, 24'h800000, 48'h400000000000};
    vecs[2] = '{"small",      24'h000003, 24'h000005, 48'h00000000000F};
    vecs[3] = '{"zero_mcand", 24'h000000, 24'hABCDEF, 48'h000000000000};
    vecs[4] = '{"one_mcand",  24'h000001, 24'hABCDEF, 48'h000000ABCDEF};
    vecs[5] = '{"ones_x2",    24'hFFFFFF, 24'h000002, 48'h000001FFFFFE};
    vecs[6] = '{"shift4",     24'h123456, 24'h000010, 48'h000001234560};
    vecs[7] = '{"msb_lsb_x2", 24'h800001, 24'h000002, 48'h000001000002};

    start24 = 1'b0; flush24 = 1'b0; out_ready24 = 1'b1;
    mcand24 = '0;   mplier24 = '0;
    start8  = 1'b0; flush8  = 1'b0; out_ready8  = 1'b1;
    mcand8  = '0;   mplier8  = '0;

    // Reset values while rst_n is low.
    #3;
    chk("rst_in_ready",  64'(in_ready24),  64'd1);
    chk("rst_out_valid", 64'(out_valid24), 64'd0);
    chk("rst_busy",      64'(busy24),      64'd0);
    chk("rst_product",   64'(product24),   64'd0);
    chk("rst_state",     64'(dbg24),       64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table: latency, busy cycles, product, then return to IDLE.
    for (int i = 0; i < 8; i++) begin
      run24(vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("%s_latency", vecs[i].name), 64'(lat),  64'd25);
      chk($sformatf("%s_busy",    vecs[i].name), 64'(bcnt), 64'd24);
      chk($sformatf("%s_product", vecs[i].name), 64'(product24), 64'(vecs[i].p));
      step();
      chk($sformatf("%s_idle",    vecs[i].name), 64'(in_ready24),  64'd1);
      chk($sformatf("%s_drop",    vecs[i].name), 64'(out_valid24), 64'd0);
    end

    // Back-pressure: held result, start ignored while DONE.
    out_ready24 = 1'b0;
    run24(24'h000003, 24'h000007, lat, bcnt);
    chk("bp_latency", 64'(lat), 64'd25);
    for (int k = 0; k < 10; k++) begin
      start24  = (k == 4);
      mcand24  = 24'h000009;
      mplier24 = 24'h000009;
      step();
      chk("bp_valid",    64'(out_valid24), 64'd1);
      chk("bp_product",  64'(product24),   64'h15);
      chk("bp_in_ready", 64'(in_ready24),  64'd0);
    end
    // Transfer edge with start high: start only taken on the following edge.
    out_ready24 = 1'b1;
    start24  = 1'b1;
    mcand24  = 24'h000002;
    mplier24 = 24'h000003;
    step();
    chk("bp_release_idle",  64'(in_ready24),  64'd1);
    chk("bp_release_valid", 64'(out_valid24), 64'd0);
    chk("bp_release_busy",  64'(busy24),      64'd0);
    step();
    chk("bp_next_busy", 64'(busy24), 64'd1);
    start24  = 1'b0;
    mcand24  = 24'h5A5A5A;
    mplier24 = 24'hA5A5A5;
    lat  = 1;
    bcnt = 1;
    wait_valid24(lat, bcnt);
    chk("bp_next_latency", 64'(lat),       64'd25);
    chk("bp_next_product", 64'(product24), 64'd6);
    step();

    // Flush during iteration 10.
    mcand24  = 24'hFFFFFF;
    mplier24 = 24'hFFFFFF;
    start24  = 1'b1;
    step();
    start24 = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("flush_pre_busy", 64'(busy24), 64'd1);
    flush24 = 1'b1;
    step();
    flush24 = 1'b0;
    chk("flush_idle",  64'(in_ready24),  64'd1);
    chk("flush_busy",  64'(busy24),      64'd0);
    chk("flush_state", 64'(dbg24),       64'(IDLE));
    seen = out_valid24;
    for (int k = 0; k < 30; k++) begin
      step();
      seen = seen | out_valid24;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);

    // Flush and start together in IDLE: start must not be taken.
    flush24 = 1'b1;
    start24 = 1'b1;
    step();
    flush24 = 1'b0;
    start24 = 1'b0;
    chk("flush_start_idle", 64'(in_ready24), 64'd1);
    chk("flush_start_busy", 64'(busy24),     64'd0);

    // A full multiply after the flush still takes the whole iteration count.
    run24(24'h000003, 24'h000005, lat, bcnt);
    chk("post_flush_latency", 64'(lat),       64'd25);
    chk("post_flush_product", 64'(product24), 64'hF);
    step();

    // Asynchronous reset while holding a result in DONE.
    out_ready24 = 1'b0;
    run24(24'hFFFFFF, 24'hFFFFFF, lat, bcnt);
    chk("rst_done_valid_pre", 64'(out_valid24), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_done_valid",    64'(out_valid24), 64'd0);
    chk("rst_done_product",  64'(product24),   64'd0);
    chk("rst_done_in_ready", 64'(in_ready24),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready24 = 1'b1;
    step();

    // Random sweep with stalls on both widths.
    fork
      rand24(400);
      rand8(1000);
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
